// File: rtl/can_tx_frame_serializer.sv
// CAN 2.0A/B transmit serializer: SOF..EOF with bit stuffing, CRC-15, arbitration and ACK monitoring.
// Optional macro CAN_TX_AUTO_RETX_EN keeps the latched frame and retries after a failed attempt.
module can_tx_frame_serializer #(
  parameter int EOF_BITS  = 7,
  parameter int STUFF_LEN = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tx_point_i,
  input  logic        sample_point_i,
  input  logic        rx_bit_i,
  input  logic        bus_idle_i,
  input  logic        tx_req_i,
  input  logic        ide_i,
  input  logic        rtr_i,
  input  logic [28:0] id_i,
  input  logic [3:0]  dlc_i,
  input  logic [63:0] data_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        tx_start_o,
  output logic        tx_done_o,
  output logic        arb_lost_o,
  output logic        bit_err_o,
  output logic        ack_err_o
);

  // Encoding order matters: SOF..CRC is a contiguous range (stuffed region).
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_SOF      = 4'd1;
  localparam logic [3:0] S_ID_A     = 4'd2;
  localparam logic [3:0] S_SRR      = 4'd3;
  localparam logic [3:0] S_IDE      = 4'd4;
  localparam logic [3:0] S_ID_B     = 4'd5;
  localparam logic [3:0] S_RTR      = 4'd6;
  localparam logic [3:0] S_R1       = 4'd7;
  localparam logic [3:0] S_R0       = 4'd8;
  localparam logic [3:0] S_DLC      = 4'd9;
  localparam logic [3:0] S_DATA     = 4'd10;
  localparam logic [3:0] S_CRC      = 4'd11;
  localparam logic [3:0] S_CRC_DEL  = 4'd12;
  localparam logic [3:0] S_ACK_SLOT = 4'd13;
  localparam logic [3:0] S_ACK_DEL  = 4'd14;
  localparam logic [3:0] S_EOF      = 4'd15;

  logic [3:0]  st_q, st_n;
  logic [6:0]  cnt_q, cnt_n;
  logic [3:0]  run_q, run_n;
  logic        last_q, last_n;
  logic [14:0] crc_q, crc_n;
  logic        stuff_q, tx_q;
  logic        ide_q, rtr_q;
  logic [28:0] id_q;
  logic [3:0]  dlc_q;
  logic [63:0] data_q;
  logic        err_arb, err_bit, err_ack, done;
  logic        in_arb, in_stuff, crc_en, mismatch;
  logic [6:0]  data_bits;
  logic        stuff_pend, next_bit;
  logic        start, restart;
  logic        tx_start_q, tx_done_q, arb_lost_q, bit_err_q, ack_err_q;
  logic [4:0]  idx_a, idx_b;
  logic [5:0]  idx_d;
  logic [3:0]  idx_c;
  logic [1:0]  idx_l;

  assign data_bits = (rtr_q || dlc_q == 4'd0) ? 7'd0 :
                     (dlc_q > 4'd8) ? 7'd64 : {dlc_q, 3'b000};

  always_comb begin
    st_n    = st_q;
    cnt_n   = cnt_q;
    run_n   = run_q;
    last_n  = last_q;
    crc_n   = crc_q;
    err_arb = 1'b0;
    err_bit = 1'b0;
    err_ack = 1'b0;
    done    = 1'b0;
    mismatch = rx_bit_i != tx_q;
    in_arb   = (st_q == S_ID_A) || (st_q == S_SRR) || (st_q == S_IDE) ||
               (st_q == S_ID_B) || (st_q == S_RTR);
    in_stuff = (st_q >= S_SOF) && (st_q <= S_CRC);
    crc_en   = in_stuff && (st_q != S_CRC);

    if (sample_point_i && st_q != S_IDLE) begin
      if (stuff_q) begin
        if (mismatch) begin
          err_bit = 1'b1;
        end else begin
          run_n  = 4'd1;
          last_n = tx_q;
        end
      end else if (st_q == S_ACK_SLOT) begin
        err_ack = rx_bit_i;
      end else if (mismatch) begin
        if (in_arb && tx_q) err_arb = 1'b1;
        else                err_bit = 1'b1;
      end

      if (!stuff_q && !err_arb && !err_bit && !err_ack) begin
        if (in_stuff) begin
          run_n  = (tx_q == last_q) ? run_q + 4'd1 : 4'd1;
          last_n = tx_q;
        end
        if (crc_en)
          crc_n = {crc_q[13:0], 1'b0} ^ ((tx_q ^ crc_q[14]) ? 15'h4599 : 15'h0000);
        cnt_n = cnt_q + 7'd1;
        case (st_q)
          S_SOF:      st_n = S_ID_A;
          S_ID_A:     if (cnt_q == 7'd10) st_n = ide_q ? S_SRR : S_RTR;
          S_SRR:      st_n = S_IDE;
          S_IDE:      st_n = ide_q ? S_ID_B : S_R0;
          S_ID_B:     if (cnt_q == 7'd17) st_n = S_RTR;
          S_RTR:      st_n = ide_q ? S_R1 : S_IDE;
          S_R1:       st_n = S_R0;
          S_R0:       st_n = S_DLC;
          S_DLC:      if (cnt_q == 7'd3) st_n = (data_bits == 7'd0) ? S_CRC : S_DATA;
          S_DATA:     if (cnt_q == data_bits - 7'd1) st_n = S_CRC;
          S_CRC:      if (cnt_q == 7'd14) st_n = S_CRC_DEL;
          S_CRC_DEL: begin
            st_n  = S_ACK_SLOT;
            run_n = 4'd0;
          end
          S_ACK_SLOT: st_n = S_ACK_DEL;
          S_ACK_DEL:  st_n = S_EOF;
          S_EOF: if (cnt_q == 7'(EOF_BITS - 1)) begin
            st_n = S_IDLE;
            done = 1'b1;
          end
          default:    st_n = S_IDLE;
        endcase
        if (st_n != st_q) cnt_n = 7'd0;
      end
      if (err_arb || err_bit || err_ack) st_n = S_IDLE;
    end

    // Next driven bit is derived from post-sample state so a coincident sample wins.
    idx_a = 5'd28 - cnt_n[4:0];
    idx_b = 5'd17 - cnt_n[4:0];
    idx_d = 6'd63 - cnt_n[5:0];
    idx_c = 4'd14 - cnt_n[3:0];
    idx_l = 2'd3 - cnt_n[1:0];
    stuff_pend = run_n == 4'(STUFF_LEN);
    case (st_n)
      S_SOF:  next_bit = 1'b0;
      S_ID_A: next_bit = id_q[idx_a];
      S_IDE:  next_bit = ide_q;
      S_ID_B: next_bit = id_q[idx_b];
      S_RTR:  next_bit = rtr_q;
      S_R1:   next_bit = 1'b0;
      S_R0:   next_bit = 1'b0;
      S_DLC:  next_bit = dlc_q[idx_l];
      S_DATA: next_bit = data_q[idx_d];
      S_CRC:  next_bit = crc_n[idx_c];
      default: next_bit = 1'b1;
    endcase
    if (stuff_pend) next_bit = ~last_n;
  end

`ifdef CAN_TX_AUTO_RETX_EN
  logic pend_q;
  assign start   = ~pend_q & tx_req_i & bus_idle_i;
  assign restart = pend_q & bus_idle_i;
  assign busy_o  = (st_q != S_IDLE) | pend_q;
`else
  assign start   = tx_req_i & bus_idle_i;
  assign restart = 1'b0;
  assign busy_o  = st_q != S_IDLE;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q       <= S_IDLE;
      cnt_q      <= 7'd0;
      run_q      <= 4'd0;
      last_q     <= 1'b1;
      crc_q      <= 15'd0;
      stuff_q    <= 1'b0;
      tx_q       <= 1'b1;
      ide_q      <= 1'b0;
      rtr_q      <= 1'b0;
      id_q       <= 29'd0;
      dlc_q      <= 4'd0;
      data_q     <= 64'd0;
      tx_start_q <= 1'b0;
      tx_done_q  <= 1'b0;
      arb_lost_q <= 1'b0;
      bit_err_q  <= 1'b0;
      ack_err_q  <= 1'b0;
`ifdef CAN_TX_AUTO_RETX_EN
      pend_q     <= 1'b0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      tx_done_q  <= 1'b0;
      arb_lost_q <= 1'b0;
      bit_err_q  <= 1'b0;
      ack_err_q  <= 1'b0;
      st_q       <= st_n;
      cnt_q      <= cnt_n;
      run_q      <= run_n;
      last_q     <= last_n;
      crc_q      <= crc_n;
      if (err_arb || err_bit || err_ack) begin
        tx_q       <= 1'b1;
        stuff_q    <= 1'b0;
        arb_lost_q <= err_arb;
        bit_err_q  <= err_bit;
        ack_err_q  <= err_ack;
      end else if (done) begin
        tx_done_q <= 1'b1;
`ifdef CAN_TX_AUTO_RETX_EN
        pend_q    <= 1'b0;
`endif
      end else if (tx_point_i) begin
        if (st_q == S_IDLE) begin
          if (start || restart) begin
            st_q    <= S_SOF;
            cnt_q   <= 7'd0;
            run_q   <= 4'd0;
            last_q  <= 1'b1;
            crc_q   <= 15'd0;
            stuff_q <= 1'b0;
            tx_q    <= 1'b0;
            if (start) begin
              ide_q      <= ide_i;
              rtr_q      <= rtr_i;
              id_q       <= id_i;
              dlc_q      <= dlc_i;
              data_q     <= data_i;
              tx_start_q <= 1'b1;
`ifdef CAN_TX_AUTO_RETX_EN
              pend_q     <= 1'b1;
`endif
            end
          end
        end else begin
          tx_q    <= next_bit;
          stuff_q <= stuff_pend;
        end
      end
    end
  end

  assign tx_o       = tx_q;
  assign tx_start_o = tx_start_q;
  assign tx_done_o  = tx_done_q;
  assign arb_lost_o = arb_lost_q;
  assign bit_err_o  = bit_err_q;
  assign ack_err_o  = ack_err_q;

endmodule

// File: doc/can_tx_frame_serializer.md
Name: can_tx_frame_serializer

Overview:
Bit-level transmitter for classical CAN 2.0A/B data and remote frames. It is the counterpart of the receive-side protocol control FSM. It latches a frame request and serializes SOF through EOF onto tx_o, with bit stuffing, CRC-15, arbitration monitoring and ACK checking. Bit timing comes from strobes supplied by the bit-timing logic; error/overload frame generation stays in the receive path.

Parameters:
EOF_BITS, 7, number of recessive EOF bits driven after ACK delimiter
STUFF_LEN, 5, identical-bit run length that triggers a stuff bit

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous reset, active-high
tx_point_i  input  1  one-cycle strobe: drive next bit
sample_point_i  input  1  one-cycle strobe: bus value valid on rx_bit_i
rx_bit_i  input  1  sampled bus level (0 = dominant)
bus_idle_i  input  1  receiver reports bus idle/intermission complete
tx_req_i  input  1  level request to transmit
ide_i  input  1  1 = extended (29-bit) frame
rtr_i  input  1  1 = remote frame
id_i  input  29  identifier; standard uses id_i[28:18]
dlc_i  input  4  data length code
data_i  input  64  byte0 in [63:56]
tx_o  output  1  CAN TX line (1 = recessive)
busy_o  output  1  frame in progress
tx_start_o  output  1  pulse: request accepted, fields latched
tx_done_o  output  1  pulse: EOF completed successfully
arb_lost_o  output  1  pulse: arbitration lost
bit_err_o  output  1  pulse: transmitted/received mismatch outside arbitration/ACK slot
ack_err_o  output  1  pulse: ACK slot sampled recessive

Behaviour:
- Reset: tx_o=1, all pulses 0, busy_o=0, state IDLE, counters/CRC cleared. Reset mid-frame aborts immediately with no status pulse.
- States: IDLE, SOF, ID_A (11), SRR, IDE, ID_B (18), RTR, R1, R0, DLC, DATA, CRC (15), CRC_DEL, ACK_SLOT, ACK_DEL, EOF. Standard frames run SOF→ID_A→RTR→IDE→R0→DLC; extended frames run SOF→ID_A→SRR→IDE→ID_B→RTR→R1→R0→DLC.
- Fixed bit values: SRR=1, IDE=ide, r1=r0=0, CRC_DEL=ACK_SLOT=ACK_DEL=EOF=1.
- Start: in IDLE, tx_req_i & bus_idle_i at tx_point_i → latch all fields, tx_o<=0 (SOF), tx_start_o pulse, busy_o=1. Inputs are don't-care after the latch.
- tx_o changes only on tx_point_i. Checks, counter updates and state advance happen only on sample_point_i. If both strobes fall in the same cycle, sample processing runs first.
- DATA length = min(dlc,8) bytes. DLC 9..15 is transmitted as-is but sends 8 bytes. Remote frame or DLC 0 goes DLC→CRC.
- Stuffing spans SOF through the last CRC bit. After STUFF_LEN identical transmitted bits (stuff bits included), the next tx_point drives the complement. A stuff bit is excluded from CRC and field counters and restarts the run count at 1. A stuff bit after the final CRC bit is inserted.
- CRC-15, polynomial 0x4599, init 0, computed over unstuffed bits SOF..last data bit, sent MSB first.
- Arbitration (ID_A, SRR, IDE, ID_B, RTR): tx_o=1 & rx_bit_i=0 at sample → arb_lost_o pulse, tx_o=1, IDLE. tx_o=0 & rx=1 → bit_err_o.
- Other bits before ACK_SLOT and after it: any mismatch → bit_err_o pulse, tx_o=1, IDLE. Stuff bits are checked too.
- ACK_SLOT: rx=1 → ack_err_o pulse, IDLE. rx=0 → continue.
- EOF: after the last of EOF_BITS sampled recessive → tx_done_o pulse, busy_o=0, IDLE. Dominant in EOF → bit_err_o.
- Only one status pulse per frame attempt. busy_o drops in the same cycle as the pulse.

Optional Feature:
CAN_TX_AUTO_RETX_EN. When defined, after arb_lost_o, bit_err_o or ack_err_o the latched frame is kept. It restarts when bus_idle_i is seen at a tx_point, without re-sampling inputs, and busy_o stays 1 between attempts. tx_start_o pulses only on the first attempt. When undefined, the block is single-shot: each attempt ends in IDLE, and a new attempt needs tx_req_i still high, which re-latches the inputs.

Test Plan:
- Std ID 0x000, DLC 0, data frame, bus echoes tx → 6th driven bit is stuff 1 after SOF+ID[10:7]=0; CRC equals the model; ACK forced 0 → tx_done_o once, total bits match the model count.
- Ext ID 0x1ABCDEF5, DLC 8, data 0x0123456789ABCDEF, echo + ACK → SRR=1, IDE=1, R1=R0=0 observed; bit stream equals the golden model; tx_done_o.
- Std ID 0x7FF, bus forces dominant at ID bit 3 → arb_lost_o at that sample, tx_o=1 thereafter, busy_o=0 (undefined macro); with macro, retry starts on the next bus_idle_i.
- Std ID 0x123, DLC 1, data 0xAA, ACK slot left recessive → ack_err_o single pulse, no tx_done_o.
- Force rx=1 while tx_o drives dominant DLC bit → bit_err_o; also assert rst_i mid-DATA → tx_o=1, all pulses 0 next cycle.
- Remote frame, std ID 0x555, DLC 15 → no DATA bits, DLC=1111 sent, CRC follows immediately.
